// File: rtl/bus_addr_ctrl_pkg.sv
// Shared types and constants for the bus address decoder / transaction controller.
package bus_addr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DECODE  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [15:0] DEF_BASE  = {8'h70, 8'h00};
  localparam logic [15:0] DEF_LIMIT = {8'h72, 8'h08};

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bus_addr_ctrl_dec.sv
// Combinational page-window compare with lowest-index priority encode.
module bus_addr_ctrl_dec
  import bus_addr_ctrl_pkg::*;
#(
  parameter int PAGE_W = 8,
  parameter int N_SLV  = 2,
  parameter int IDX_W  = (N_SLV > 1) ? $clog2(N_SLV) : 1,
  parameter logic [N_SLV*PAGE_W-1:0] BASE  = DEF_BASE,
  parameter logic [N_SLV*PAGE_W-1:0] LIMIT = DEF_LIMIT
) (
  input  logic [PAGE_W-1:0] i_page,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_idx
);

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if ((i_page >= BASE[k*PAGE_W +: PAGE_W]) && (i_page < LIMIT[k*PAGE_W +: PAGE_W])) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(k);
      end else begin
        o_hit = o_hit;
        o_idx = o_idx;
      end
    end
  end

endmodule

// File: rtl/bus_addr_ctrl.sv
// Registered address decoder and transaction controller: holds a one-hot
// slave select per transaction and reports ack, decode miss or timeout.
module bus_addr_ctrl
  import bus_addr_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int PAGE_W  = 8,
  parameter int N_SLV   = 2,
  parameter logic [N_SLV*PAGE_W-1:0] BASE  = DEF_BASE,
  parameter logic [N_SLV*PAGE_W-1:0] LIMIT = DEF_LIMIT,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_req,
  input  logic [ADDR_W-1:0] address,
  input  logic [N_SLV-1:0]  s_ack,
  output logic [N_SLV-1:0]  s_sel,
  output logic              m_ack,
  output logic              m_err,
  output logic [1:0]        err_code,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N_SLV-1:0] SEL_ONE  = N_SLV'(1);

  state_e             r_state, w_state_nxt;
  logic [N_SLV-1:0]   r_sel, w_sel_nxt;
  logic               r_ack, w_ack_nxt;
  logic               r_err, w_err_nxt;
  logic [1:0]         r_code, w_code_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_busy;
  logic [7:0]         r_err_cnt;
  logic               w_hit;
  logic [IDX_W-1:0]   w_dec_idx;
  logic               w_sel_ack;
  logic               w_unused_addr;

  assign w_unused_addr = &{1'b0, address[ADDR_W-PAGE_W-1:0]};

  bus_addr_ctrl_dec #(
    .PAGE_W (PAGE_W),
    .N_SLV  (N_SLV),
    .IDX_W  (IDX_W),
    .BASE   (BASE),
    .LIMIT  (LIMIT)
  ) u_dec (
    .i_page (address[ADDR_W-1 -: PAGE_W]),
    .o_hit  (w_hit),
    .o_idx  (w_dec_idx)
  );

  // Only the currently selected slave may complete the transaction.
  assign w_sel_ack = |(s_ack & r_sel);

  // Next-state and next-output logic; ack has priority over abort and timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_code_nxt  = ERR_NONE;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_sel_nxt = '0;
        if (m_req) begin
          if (w_hit) begin
            w_sel_nxt   = SEL_ONE << w_dec_idx;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_ACTIVE;
          end else begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_DECODE;
            w_state_nxt = ST_RESP;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (w_sel_ack) begin
          w_sel_nxt   = '0;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (!m_req) begin
          w_sel_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_sel_nxt   = '0;
          w_err_nxt   = 1'b1;
          w_code_nxt  = ERR_TIMEOUT;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      ST_RESP: begin
        w_sel_nxt   = '0;
        w_state_nxt = m_req ? ST_RELEASE : ST_IDLE;
      end
      ST_RELEASE: begin
        w_sel_nxt   = '0;
        w_state_nxt = m_req ? ST_RELEASE : ST_IDLE;
      end
      default: begin
        w_sel_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; err_cnt moves on the same edge m_err rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_code    <= ERR_NONE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      r_code    <= w_code_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_err_cnt <= w_err_nxt ? sat_inc8(r_err_cnt) : r_err_cnt;
    end
  end

  assign s_sel    = r_sel;
  assign m_ack    = r_ack;
  assign m_err    = r_err;
  assign err_code = r_code;
  assign busy     = r_busy;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_bus_addr_ctrl.sv
// Directed, table-driven bench for bus_addr_ctrl with default parameters.
module tb_bus_addr_ctrl;

  typedef struct packed {
    logic        m_req;
    logic [15:0] addr;
    logic [1:0]  ack;
    logic [1:0]  sel;
    logic        mack;
    logic        merr;
    logic [1:0]  code;
    logic        busy;
    logic [7:0]  ecnt;
  } vec_t;

  localparam int NV = 24;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        m_req    = 1'b0;
  logic [15:0] address  = 16'h0000;
  logic [1:0]  s_ack    = 2'b00;
  logic [1:0]  s_sel;
  logic        m_ack;
  logic        m_err;
  logic [1:0]  err_code;
  logic        busy;
  logic [7:0]  err_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[NV];

  bus_addr_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .m_req    (m_req),
    .address  (address),
    .s_ack    (s_ack),
    .s_sel    (s_sel),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .err_code (err_code),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {17'd0, s_sel, m_ack, m_err, err_code, busy, err_cnt};
  endfunction

  initial begin
    //            req   addr      ack    sel    mack  merr  code   busy  ecnt
    vecs[0]  = '{1'b1, 16'h0345, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 8'd0};
    vecs[1]  = '{1'b1, 16'h0345, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 8'd0};
    vecs[2]  = '{1'b1, 16'h0345, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 8'd0};
    vecs[3]  = '{1'b1, 16'h0345, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 8'd0};
    vecs[4]  = '{1'b1, 16'h0345, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 8'd0};
    vecs[5]  = '{1'b1, 16'h0345, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 8'd0};
    vecs[6]  = '{1'b1, 16'h0345, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 8'd0};
    vecs[7]  = '{1'b0, 16'h0345, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0};
    vecs[8]  = '{1'b1, 16'h5000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1, 8'd1};
    vecs[9]  = '{1'b1, 16'h5000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 8'd1};
    vecs[10] = '{1'b1, 16'h0345, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 8'd1};
    vecs[11] = '{1'b0, 16'h5000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd1};
    vecs[12] = '{1'b1, 16'h0345, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 8'd1};
    vecs[13] = '{1'b1, 16'h7180, 2'b10, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 8'd1};
    vecs[14] = '{1'b0, 16'h0345, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd1};
    vecs[15] = '{1'b1, 16'h7000, 2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 8'd1};
    vecs[16] = '{1'b0, 16'h7000, 2'b10, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 8'd1};
    vecs[17] = '{1'b0, 16'h7000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd1};
    vecs[18] = '{1'b1, 16'h72FF, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1, 8'd2};
    vecs[19] = '{1'b0, 16'h72FF, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd2};
    vecs[20] = '{1'b1, 16'h07FF, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 8'd2};
    vecs[21] = '{1'b0, 16'h07FF, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd2};
    vecs[22] = '{1'b1, 16'h0800, 2'b11, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1, 8'd3};
    vecs[23] = '{1'b0, 16'h0800, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd3};

    tick();
    tick();
    check("reset_state", outs(), 32'd0);

    // Reset taken in the middle of an ACTIVE transaction.
    reset = 1'b0; m_req = 1'b1; address = 16'h0345;
    tick();
    check("pre_reset_sel", outs(), {17'd0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 8'd0});
    reset = 1'b1;
    tick();
    check("mid_active_reset", outs(), 32'd0);
    reset = 1'b0; m_req = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      m_req = vecs[i].m_req; address = vecs[i].addr; s_ack = vecs[i].ack;
      tick();
      check($sformatf("vec%0d", i), outs(),
            {17'd0, vecs[i].sel, vecs[i].mack, vecs[i].merr, vecs[i].code, vecs[i].busy, vecs[i].ecnt});
    end
    s_ack = 2'b00; m_req = 1'b0;
    tick();

    // Timeout: select held exactly 16 cycles, then timeout error.
    m_req = 1'b1; address = 16'h7180;
    for (int c = 0; c < 16; c++) begin
      tick();
      check($sformatf("to_hold%0d", c), {29'd0, s_sel, m_err}, {29'd0, 2'b10, 1'b0});
    end
    tick();
    check("to_err", outs(), {17'd0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, 8'd4});
    m_req = 1'b0;
    tick();
    check("to_idle", {31'd0, busy}, 32'd0);

    // Decode miss with request held: only one error.
    m_req = 1'b1; address = 16'h5000;
    tick();
    check("miss_err", outs(), {17'd0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1, 8'd5});
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("miss_hold%0d", c), {29'd0, m_err, busy, s_sel[0]}, {29'd0, 1'b0, 1'b1, 1'b0});
    end
    m_req = 1'b0;
    tick();
    check("miss_release", {23'd0, busy, err_cnt}, {23'd0, 1'b0, 8'd5});

    // Ack arriving on the last timeout cycle wins.
    m_req = 1'b1; address = 16'h7180;
    for (int c = 0; c < 16; c++) tick();
    s_ack = 2'b10;
    tick();
    check("ack_vs_timeout", outs(), {17'd0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 8'd5});
    s_ack = 2'b00; m_req = 1'b0;
    tick();

    // Error counter saturation over 300 decode misses.
    address = 16'h5000;
    for (int c = 0; c < 300; c++) begin
      m_req = 1'b1;
      tick();
      m_req = 1'b0;
      tick();
    end
    check("err_cnt_sat", {24'd0, err_cnt}, {24'd0, 8'hFF});

    reset = 1'b1;
    tick();
    check("reset_clears_cnt", outs(), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
